// File: rtl/connect4_pkg.sv
// Shared codes for the Connect4 move judge and the game-flow FSM: status, FSM
// state and piece encodings, board defaults, judge states and scan directions.
package connect4_pkg;

  localparam int DEF_COLS    = 7;
  localparam int DEF_ROWS    = 6;
  localparam int DEF_WIN_LEN = 4;

  localparam logic [1:0] STATUS_NEXT_TURN = 2'b00;
  localparam logic [1:0] STATUS_P1_WIN    = 2'b01;
  localparam logic [1:0] STATUS_P2_WIN    = 2'b10;
  localparam logic [1:0] STATUS_TIE       = 2'b11;

  localparam logic [1:0] FSM_GAME_INIT = 2'b00;
  localparam logic [1:0] FSM_P1_TURN   = 2'b01;
  localparam logic [1:0] FSM_P2_TURN   = 2'b10;
  localparam logic [1:0] FSM_END_GAME  = 2'b11;

  localparam logic [1:0] PIECE_EMPTY = 2'b00;
  localparam logic [1:0] PIECE_P1    = 2'b01;
  localparam logic [1:0] PIECE_P2    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PLACE, ST_CHECK_H, ST_CHECK_V,
    ST_CHECK_D1, ST_CHECK_D2, ST_RESOLVE, ST_OVER
  } judge_state_e;

  // D1 runs up-right, D2 runs up-left; the opposite side is the negated step.
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D1, DIR_D2} dir_e;

  function automatic int dir_dc(input dir_e d);
    case (d)
      DIR_H:   return 1;
      DIR_D1:  return 1;
      DIR_D2:  return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dr(input dir_e d);
    case (d)
      DIR_H:   return 0;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/connect4_line_counter.sv
// Combinational run counter: length of the same-colour line through one cell
// along one axis, each side saturating at WIN_LEN-1 and stopping at the edge.
module connect4_line_counter
  import connect4_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic [2*COLS*ROWS-1:0] board_flat_i,
  input  logic [2:0]             col_i,
  input  logic [2:0]             row_i,
  input  logic [1:0]             colour_i,
  input  logic [1:0]             dir_i,
  output logic [3:0]             run_len_o
);

  always_comb begin
    int dc, dr, c, r, sgn, total;
    logic alive;
    logic [2*COLS*ROWS-1:0] shifted;
    dc    = dir_dc(dir_e'(dir_i));
    dr    = dir_dr(dir_e'(dir_i));
    total = 1;
    c     = 0;
    r     = 0;
    sgn   = 1;
    alive = 1'b1;
    shifted = '0;
    for (int s = 0; s < 2; s++) begin
      sgn   = (s == 0) ? 1 : -1;
      alive = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        c = int'(col_i) + sgn * k * dc;
        r = int'(row_i) + sgn * k * dr;
        if (alive && c >= 0 && c < COLS && r >= 0 && r < ROWS) begin
          shifted = board_flat_i >> (2 * (r * COLS + c));
          if (shifted[1:0] == colour_i) total = total + 1;
          else alive = 1'b0;
        end else begin
          alive = 1'b0;
        end
      end
    end
    run_len_o = 4'(total);
  end

endmodule

// File: rtl/connect4_move_judge.sv
// Connect4 move engine and referee: gravity placement, win/tie detection, turn
// tracking. Define CONNECT4_DIAG_CHECK_EN to add the two diagonal checks.
module connect4_move_judge
  import connect4_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             fsm_state,
  input  logic                   drop_valid,
  input  logic [2:0]             col_sel,
  output logic                   drop_ready,
  output logic                   drop_reject,
  output logic [1:0]             game_status,
  output logic                   player_turn,
  output logic [2*COLS*ROWS-1:0] board_flat,
  output logic [2:0]             judge_state
);

  localparam int CELLS = COLS * ROWS;
  localparam int HW    = $clog2(ROWS + 1);
  localparam int CW    = $clog2(CELLS + 1);
  localparam logic [2:0]    COLS_L  = 3'(COLS);
  localparam logic [HW-1:0] ROWS_L  = HW'(ROWS);
  localparam logic [CW-1:0] CELLS_L = CW'(CELLS);
  localparam logic [3:0]    WIN_L   = 4'(WIN_LEN);

  judge_state_e      state_q;
  logic [2*CELLS-1:0] board_q;
  logic [HW-1:0]     height_q [COLS];
  logic [CW-1:0]     piece_cnt_q;
  logic              win_q, turn_q, reject_q;
  logic [1:0]        status_q, colour_q;
  logic [2:0]        col_q, row_q;

  logic [HW-1:0] sel_height;
  logic          mover_ok, drop_legal, run_hit;
  logic [1:0]    dir;
  logic [3:0]    run_len;
  int            place_idx;

  always_comb begin
    sel_height = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_sel == 3'(c)) sel_height = height_q[c];
    end
  end

  // A drop is only legal when the game-flow FSM agrees whose turn it is.
  assign mover_ok   = (fsm_state == FSM_P1_TURN && !turn_q) ||
                      (fsm_state == FSM_P2_TURN &&  turn_q);
  assign drop_legal = drop_valid && (col_sel < COLS_L) && (sel_height < ROWS_L) && mover_ok;
  assign place_idx  = int'(row_q) * COLS + int'(col_q);

  always_comb begin
    dir = DIR_H;
    case (state_q)
      ST_CHECK_V:  dir = DIR_V;
      ST_CHECK_D1: dir = DIR_D1;
      ST_CHECK_D2: dir = DIR_D2;
      default:     dir = DIR_H;
    endcase
  end

  connect4_line_counter #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) u_line_counter (
    .board_flat_i (board_q),
    .col_i        (col_q),
    .row_i        (row_q),
    .colour_i     (colour_q),
    .dir_i        (dir),
    .run_len_o    (run_len)
  );

  assign run_hit = (run_len >= WIN_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
      piece_cnt_q <= '0;
      win_q       <= 1'b0;
      turn_q      <= 1'b0;
      reject_q    <= 1'b0;
      status_q    <= STATUS_NEXT_TURN;
      colour_q    <= PIECE_EMPTY;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fsm_state == FSM_END_GAME) begin
            state_q <= ST_OVER;
          end else if (drop_legal) begin
            col_q    <= col_sel;
            row_q    <= 3'(sel_height);
            colour_q <= turn_q ? PIECE_P2 : PIECE_P1;
            win_q    <= 1'b0;
            state_q  <= ST_PLACE;
          end else if (drop_valid) begin
            reject_q <= 1'b1;
          end
        end
        ST_PLACE: begin
          for (int i = 0; i < CELLS; i++) begin
            if (i == place_idx) board_q[2*i +: 2] <= colour_q;
          end
          for (int c = 0; c < COLS; c++) begin
            if (col_q == 3'(c)) height_q[c] <= height_q[c] + HW'(1);
          end
          piece_cnt_q <= piece_cnt_q + CW'(1);
          state_q     <= ST_CHECK_H;
        end
        ST_CHECK_H: begin
          win_q   <= win_q | run_hit;
          state_q <= ST_CHECK_V;
        end
        ST_CHECK_V: begin
          win_q <= win_q | run_hit;
`ifdef CONNECT4_DIAG_CHECK_EN
          state_q <= ST_CHECK_D1;
`else
          state_q <= ST_RESOLVE;
`endif
        end
`ifdef CONNECT4_DIAG_CHECK_EN
        ST_CHECK_D1: begin
          win_q   <= win_q | run_hit;
          state_q <= ST_CHECK_D2;
        end
        ST_CHECK_D2: begin
          win_q   <= win_q | run_hit;
          state_q <= ST_RESOLVE;
        end
`endif
        // A win on the last free cell takes priority over the tie.
        ST_RESOLVE: begin
          if (win_q) begin
            status_q <= colour_q;
            state_q  <= ST_OVER;
          end else if (piece_cnt_q == CELLS_L) begin
            status_q <= STATUS_TIE;
            state_q  <= ST_OVER;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= ST_IDLE;
          end
        end
        ST_OVER: state_q <= ST_OVER;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign drop_ready  = (state_q == ST_IDLE);
  assign drop_reject = reject_q;
  assign game_status = status_q;
  assign player_turn = turn_q;
  assign board_flat  = board_q;
  assign judge_state = state_q;

endmodule

// File: tb/tb_connect4_move_judge.sv
// Bench for connect4_move_judge: a reference game model predicts each move's
// board/status/turn/reject, queued at drive time and checked when the move ends.
`timescale 1ns/1ps
module tb_connect4_move_judge;
  import connect4_pkg::*;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;
  localparam int FW    = 2 * CELLS;
  localparam int EXP_W = FW + 4;
`ifdef CONNECT4_DIAG_CHECK_EN
  localparam int LAT  = 6;
  localparam bit DIAG = 1'b1;
`else
  localparam int LAT  = 4;
  localparam bit DIAG = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    fsm_state = 2'b01;
  logic          drop_valid = 1'b0;
  logic [2:0]    col_sel = 3'd0;
  logic          drop_ready, drop_reject, player_turn;
  logic [1:0]    game_status;
  logic [FW-1:0] board_flat;
  logic [2:0]    judge_state;

  always #5 clk = ~clk;

  connect4_move_judge dut (
    .clk         (clk),
    .reset       (reset),
    .fsm_state   (fsm_state),
    .drop_valid  (drop_valid),
    .col_sel     (col_sel),
    .drop_ready  (drop_ready),
    .drop_reject (drop_reject),
    .game_status (game_status),
    .player_turn (player_turn),
    .board_flat  (board_flat),
    .judge_state (judge_state)
  );

  // ---------------- scoreboard + checker ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference game model ----------------
  int         m_board [COLS][ROWS];
  int         m_h [COLS];
  logic       m_turn;
  logic [1:0] m_status;
  int         m_cnt;

  function automatic void model_reset();
    for (int c = 0; c < COLS; c++) begin
      m_h[c] = 0;
      for (int r = 0; r < ROWS; r++) m_board[c][r] = 0;
    end
    m_turn = 1'b0;
    m_status = 2'b00;
    m_cnt = 0;
  endfunction

  // Whole-board scan for any run of four; diagonals only when compiled in.
  function automatic bit model_win(input int p);
    int nd, dc, dr, cc, rr, run;
    nd = DIAG ? 4 : 2;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int d = 0; d < nd; d++) begin
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          dr = (d == 0) ? 0 : 1;
          run = 0;
          for (int k = 0; k < 4; k++) begin
            cc = c + k * dc;
            rr = r + k * dr;
            if (cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
              if (m_board[cc][rr] == p) run++;
            end
          end
          if (run == 4) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_place(input int col);
    int p;
    p = m_turn ? 2 : 1;
    m_board[col][m_h[col]] = p;
    m_h[col]++;
    m_cnt++;
    if (model_win(p))        m_status = 2'(p);
    else if (m_cnt == CELLS) m_status = 2'b11;
    else                     m_turn = ~m_turn;
  endfunction

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        f = f | (FW'(m_board[c][r]) << (2 * (r * COLS + c)));
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    reset = 1'b0;
    drop_valid = 1'b0;
    col_sel = 3'd0;
    fsm_state = 2'b01;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_drop(input int col, input logic [1:0] fsm);
    logic legal;
    logic [EXP_W-1:0] e;
    int n;
    n = 0;
    while (!drop_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_drop", drop_ready, 1'b1);
    if (!drop_ready) return;
    legal = 1'b0;
    if (col >= 0 && col < COLS) begin
      if (m_h[col] < ROWS && ((fsm == 2'b01 && !m_turn) || (fsm == 2'b10 && m_turn))) legal = 1'b1;
    end
    if (legal) model_place(col);
    exp_q.push_back({model_flat(), m_status, m_turn, ~legal});

    drop_valid = 1'b1;
    col_sel    = 3'(col);
    fsm_state  = fsm;
    @(negedge clk);
    drop_valid = 1'b0;
    if (!legal) begin
      e = exp_q.pop_front();
      check_eq("reject_pulse", drop_reject, e[0]);
      check_eq("reject_ready", drop_ready, 1'b1);
      check_eq("reject_board", board_flat, e[EXP_W-1 -: FW]);
      check_eq("reject_status", game_status, e[3:2]);
      check_eq("reject_turn", player_turn, e[1]);
      @(negedge clk);
      check_eq("reject_one_cycle", drop_reject, 1'b0);
    end else begin
      check_eq("accept_no_reject", drop_reject, 1'b0);
      check_eq("accept_busy", drop_ready, 1'b0);
      @(negedge clk);
      check_eq("place_visible_e1", board_flat, model_flat());
      n = 1;
      while (!(drop_ready || game_status != 2'b00) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("move_latency", n, LAT);
      e = exp_q.pop_front();
      check_eq("move_board", board_flat, e[EXP_W-1 -: FW]);
      check_eq("move_status", game_status, e[3:2]);
      check_eq("move_turn", player_turn, e[1]);
      check_eq("move_ready", drop_ready, (e[3:2] == 2'b00));
    end
  endtask

  task automatic play(input int col);
    do_drop(col, m_turn ? 2'b10 : 2'b01);
  endtask

  // ---------------- stimulus tables ----------------
  int vert_cols[7]  = '{3, 4, 3, 4, 3, 4, 3};
  int horiz_cols[12] = '{0, 6, 0, 6, 1, 5, 1, 5, 2, 4, 2, 3};
  int diag_cols[11] = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
  int tie_cols[42]  = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 1,
                        6, 3, 6, 6, 2, 3, 2, 2, 3, 2, 3, 2, 3, 3, 2,
                        6, 4, 6, 6, 5, 4, 5, 5, 4, 5, 4, 5, 4, 4, 5};

  initial begin
    int n;
    reset_dut();
    check_eq("rst_state", judge_state, ST_IDLE);
    check_eq("rst_board", board_flat, '0);
    check_eq("rst_status", game_status, 2'b00);
    check_eq("rst_turn", player_turn, 1'b0);
    check_eq("rst_ready", drop_ready, 1'b1);
    check_eq("rst_reject", drop_reject, 1'b0);

    // vertical P1 win, then OVER absorbs drops silently
    foreach (vert_cols[i]) play(vert_cols[i]);
    check_eq("vert_status", game_status, 2'b01);
    check_eq("vert_turn", player_turn, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("over_state", judge_state, ST_OVER);
    drop_valid = 1'b1;
    col_sel = 3'd0;
    fsm_state = 2'b01;
    @(negedge clk);
    check_eq("over_no_reject", drop_reject, 1'b0);
    check_eq("over_not_ready", drop_ready, 1'b0);
    @(negedge clk);
    drop_valid = 1'b0;
    check_eq("over_board_frozen", board_flat, model_flat());
    check_eq("over_status_held", game_status, 2'b01);
    check_eq("over_state_held", judge_state, ST_OVER);

    // horizontal P2 win on the bottom row
    reset_dut();
    foreach (horiz_cols[i]) play(horiz_cols[i]);
    check_eq("horiz_status", game_status, 2'b10);

    // full column, out-of-range column, FSM/turn mismatch
    reset_dut();
    repeat (6) play(0);
    play(0);
    do_drop(7, 2'b01);
    do_drop(1, 2'b10);
    play(1);
    check_eq("after_rejects_turn", player_turn, 1'b1);

    // diagonal staircase (0,0)..(3,3) for P1
    reset_dut();
    foreach (diag_cols[i]) play(diag_cols[i]);
    check_eq("diag_status", game_status, DIAG ? 2'b01 : 2'b00);

    // full board without any run of four
    reset_dut();
    foreach (tie_cols[i]) play(tie_cols[i]);
    check_eq("tie_status", game_status, 2'b11);
    check_eq("tie_ready", drop_ready, 1'b0);

    // asynchronous reset during CHECK_V discards the move
    reset_dut();
    fsm_state = 2'b01;
    col_sel = 3'd2;
    drop_valid = 1'b1;
    @(negedge clk);
    drop_valid = 1'b0;
    n = 0;
    while (judge_state != ST_CHECK_V && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reached_check_v", judge_state, ST_CHECK_V);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_state", judge_state, ST_IDLE);
    check_eq("midrst_board", board_flat, '0);
    check_eq("midrst_status", game_status, 2'b00);
    check_eq("midrst_turn", player_turn, 1'b0);
    check_eq("midrst_ready", drop_ready, 1'b1);
    check_eq("midrst_reject", drop_reject, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    play(2);
    play(2);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
